// File: rtl/irq_gateway_bank.sv
// irq_gateway_bank: per-source level/edge interrupt gateways with a
// fixed-priority (lowest id first) claim/complete front end.
module irq_gateway_bank #(
  parameter int unsigned        N_SRC     = 8,
  parameter logic [N_SRC-1:0]   EDGE_MASK = '0,
  localparam int unsigned       ID_W      = $clog2(N_SRC + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_in,
  input  logic [N_SRC-1:0] enable,
  output logic             pend_valid,
  output logic [ID_W-1:0]  pend_id,
  input  logic             claim,
  input  logic             complete,
  input  logic [ID_W-1:0]  complete_id,
  output logic [N_SRC-1:0] inflight
);

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] edge_prev;
  logic [N_SRC-1:0] edge_held;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] idle;
  logic [N_SRC-1:0] claim_hit;
  logic [N_SRC-1:0] comp_hit;

  // Fixed-priority selection; scanning downward lets the lowest id win.
  always_comb begin
    pend_valid = 1'b0;
    pend_id    = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (pending[i-1] && enable[i-1]) begin
        pend_valid = 1'b1;
        pend_id    = ID_W'(i);
      end
    end
  end

  // Per-source request detection and claim/complete decode.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      req[i]       = EDGE_MASK[i] ? (int_in[i] & ~edge_prev[i]) : int_in[i];
      idle[i]      = ~pending[i] & ~inflight[i];
      claim_hit[i] = claim & pend_valid & (pend_id == ID_W'(i + 1));
      // A complete only hits an inflight source, so it never collides with a
      // claim of the same id (claim requires pending, which excludes inflight).
      comp_hit[i]  = complete & (complete_id == ID_W'(i + 1)) & inflight[i];
    end
  end

  // Gateway state: pending/inflight handshake plus 1-deep edge merge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= '0;
      inflight  <= '0;
      edge_prev <= '0;
      edge_held <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        edge_prev[i] <= int_in[i] & EDGE_MASK[i];

        if (claim_hit[i])
          pending[i] <= 1'b0;
        else if (idle[i] && (req[i] || edge_held[i]))
          pending[i] <= 1'b1;

        // Held edge is consumed on the first idle cycle; otherwise any
        // further edge while busy is merged into the single held bit.
        if (idle[i])
          edge_held[i] <= 1'b0;
        else if (EDGE_MASK[i] && req[i])
          edge_held[i] <= 1'b1;

        if (claim_hit[i])
          inflight[i] <= 1'b1;
        else if (comp_hit[i])
          inflight[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_gateway_bank.sv
// Self-checking bench for irq_gateway_bank: directed scenarios plus a
// randomized run against a per-source behavioural model.
module tb_irq_gateway_bank;

  localparam int N = 8;
  localparam logic [7:0] EM = 8'h41;   // sources 1 and 7 are edge-triggered

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] int_in;
  logic [7:0] enable;
  logic       pend_valid;
  logic [3:0] pend_id;
  logic       claim;
  logic       complete;
  logic [3:0] complete_id;
  logic [7:0] inflight;

  int errors = 0;
  int checks = 0;

  // Model state, indexed by source id 1..N
  bit m_pend [1:N];
  bit m_infl [1:N];
  bit m_held [1:N];
  bit m_prev [1:N];

  irq_gateway_bank #(.N_SRC(8), .EDGE_MASK(8'h41)) dut (
    .clock      (clock),
    .reset      (reset),
    .int_in     (int_in),
    .enable     (enable),
    .pend_valid (pend_valid),
    .pend_id    (pend_id),
    .claim      (claim),
    .complete   (complete),
    .complete_id(complete_id),
    .inflight   (inflight)
  );

  always #5 clock = ~clock;

  // Id the consumer should see right now: lowest enabled pending source.
  function automatic int m_id();
    for (int s = 1; s <= N; s++)
      if (m_pend[s] && enable[s-1]) return s;
    return 0;
  endfunction

  function automatic logic [7:0] m_infl_vec();
    logic [7:0] v;
    v = '0;
    for (int s = 1; s <= N; s++) v[s-1] = m_infl[s];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUT take the same edge; pulses are dropped afterwards.
  task automatic step();
    bit np [1:N];
    bit ni [1:N];
    bit nh [1:N];
    int cid;
    cid = m_id();
    for (int s = 1; s <= N; s++) begin
      bit busy, lvl, rise;
      np[s] = m_pend[s]; ni[s] = m_infl[s]; nh[s] = m_held[s];
      busy = m_pend[s] || m_infl[s];
      lvl  = int_in[s-1];
      rise = lvl && !m_prev[s];
      if (EM[s-1]) begin
        if (!busy && (rise || m_held[s])) begin np[s] = 1; nh[s] = 0; end
        else if (busy && rise) nh[s] = 1;
      end else if (!busy && lvl) begin
        np[s] = 1;
      end
      if (claim && cid == s) begin np[s] = 0; ni[s] = 1; end
      if (complete && complete_id == 4'(s) && m_infl[s]) ni[s] = 0;
    end
    for (int s = 1; s <= N; s++) begin
      if (reset) begin
        m_pend[s] = 0; m_infl[s] = 0; m_held[s] = 0; m_prev[s] = 0;
      end else begin
        m_pend[s] = np[s]; m_infl[s] = ni[s]; m_held[s] = nh[s];
        m_prev[s] = int_in[s-1];
      end
    end
    @(posedge clock);
    #1;
    claim       = 1'b0;
    complete    = 1'b0;
    complete_id = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; int_in = '0; enable = 8'hFF;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d exp=0", pend_valid); end
    checks++; if (pend_id !== 4'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", pend_id); end
    checks++; if (inflight !== 8'h00) begin errors++; $display("FAIL reset_inflight got=%h exp=00", inflight); end
  endtask

  task automatic test_level_detect();
    int_in = 8'h04;
    step();
    checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL lvl_valid got=%0d exp=1", pend_valid); end
    checks++; if (pend_id !== 4'd3) begin errors++; $display("FAIL lvl_id got=%0d exp=3", pend_id); end
    int_in = 8'h00;
    step();
    checks++; if (pend_id !== 4'd3) begin errors++; $display("FAIL lvl_hold got=%0d exp=3", pend_id); end
    claim = 1'b1; step();
    complete = 1'b1; complete_id = 4'd3; step();
    checks++; if (inflight !== 8'h00 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL lvl_done got=%h/%0d exp=00/0", inflight, pend_valid); end
  endtask

  task automatic test_claim_order();
    int_in = 8'h0A;
    step();
    checks++; if (pend_id !== 4'd2) begin errors++; $display("FAIL order_first got=%0d exp=2", pend_id); end
    claim = 1'b1; step();
    checks++; if (pend_id !== 4'd4) begin errors++; $display("FAIL order_next got=%0d exp=4", pend_id); end
    checks++; if (inflight !== 8'h02) begin errors++; $display("FAIL order_infl got=%h exp=02", inflight); end
    claim = 1'b1; step();
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL order_empty got=%0d exp=0", pend_valid); end
    checks++; if (inflight !== 8'h0A) begin errors++; $display("FAIL order_infl2 got=%h exp=0a", inflight); end
    int_in = 8'h00;
    complete = 1'b1; complete_id = 4'd2; step();
    complete = 1'b1; complete_id = 4'd4; step();
    checks++; if (inflight !== 8'h00) begin errors++; $display("FAIL order_clear got=%h exp=00", inflight); end
  endtask

  task automatic test_rearm();
    int_in = 8'h04;
    step();
    claim = 1'b1; step();
    complete = 1'b1; complete_id = 4'd3; step();
    checks++; if (inflight !== 8'h00) begin errors++; $display("FAIL rearm_infl got=%h exp=00", inflight); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL rearm_early got=%0d exp=0", pend_valid); end
    step();
    checks++; if (pend_valid !== 1'b1 || pend_id !== 4'd3) begin
      errors++; $display("FAIL rearm_id got=%0d/%0d exp=1/3", pend_valid, pend_id); end
    int_in = 8'h00;
    claim = 1'b1; step();
    complete = 1'b1; complete_id = 4'd3; step();
  endtask

  task automatic test_edge_merge();
    int_in = 8'h00; step();
    int_in = 8'h01; step();
    checks++; if (pend_id !== 4'd1) begin errors++; $display("FAIL edge_first got=%0d exp=1", pend_id); end
    claim = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      int_in = 8'h00; step();
      int_in = 8'h01; step();
    end
    int_in = 8'h00; step();
    checks++; if (pend_valid !== 1'b0 || inflight !== 8'h01) begin
      errors++; $display("FAIL edge_busy got=%0d/%h exp=0/01", pend_valid, inflight); end
    complete = 1'b1; complete_id = 4'd1; step();
    checks++; if (inflight !== 8'h00 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL edge_cmpl got=%h/%0d exp=00/0", inflight, pend_valid); end
    step();
    checks++; if (pend_valid !== 1'b1 || pend_id !== 4'd1) begin
      errors++; $display("FAIL edge_held got=%0d/%0d exp=1/1", pend_valid, pend_id); end
    claim = 1'b1; step();
    complete = 1'b1; complete_id = 4'd1; step();
    step();
    checks++; if (pend_valid !== 1'b0 || inflight !== 8'h00) begin
      errors++; $display("FAIL edge_merged got=%0d/%h exp=0/00", pend_valid, inflight); end
  endtask

  task automatic test_ignored();
    int_in = 8'h04; step();
    claim = 1'b1; step();
    int_in = 8'h00;
    complete = 1'b1; complete_id = 4'd0; step();
    checks++; if (inflight !== 8'h04) begin errors++; $display("FAIL ign_id0 got=%h exp=04", inflight); end
    complete = 1'b1; complete_id = 4'd9; step();
    checks++; if (inflight !== 8'h04) begin errors++; $display("FAIL ign_id9 got=%h exp=04", inflight); end
    complete = 1'b1; complete_id = 4'd2; step();
    checks++; if (inflight !== 8'h04) begin errors++; $display("FAIL ign_notinfl got=%h exp=04", inflight); end
    claim = 1'b1; step();
    checks++; if (inflight !== 8'h04 || pend_valid !== 1'b0) begin
      errors++; $display("FAIL ign_claim got=%h/%0d exp=04/0", inflight, pend_valid); end
    complete = 1'b1; complete_id = 4'd3; step();
    checks++; if (inflight !== 8'h00) begin errors++; $display("FAIL ign_clear got=%h exp=00", inflight); end
  endtask

  task automatic test_reset_midop_enable();
    int_in = 8'h81; step();
    claim = 1'b1; step();
    claim = 1'b1; step();
    int_in = 8'h10; step();
    checks++; if (inflight !== 8'h81 || pend_id !== 4'd5) begin
      errors++; $display("FAIL mid_setup got=%h/%0d exp=81/5", inflight, pend_id); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (inflight !== 8'h00 || pend_valid !== 1'b0 || pend_id !== 4'd0) begin
      errors++; $display("FAIL mid_reset got=%h/%0d/%0d exp=00/0/0", inflight, pend_valid, pend_id); end
    enable = 8'h00; step();
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL en_masked got=%0d exp=0", pend_valid); end
    enable = 8'h10; #1;
    checks++; if (pend_valid !== 1'b1 || pend_id !== 4'd5) begin
      errors++; $display("FAIL en_show got=%0d/%0d exp=1/5", pend_valid, pend_id); end
    int_in = 8'h00; enable = 8'hFF;
    claim = 1'b1; step();
    complete = 1'b1; complete_id = 4'd5; step();
  endtask

  task automatic test_random();
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int exp_id;
      int_in      = 8'($urandom);
      enable      = 8'($urandom | $urandom);
      claim       = ($urandom_range(0, 2) == 0);
      complete    = ($urandom_range(0, 2) == 0);
      complete_id = 4'($urandom_range(0, 10));
      reset       = ($urandom_range(0, 79) == 0);
      step();
      reset = 1'b0;
      exp_id = m_id();
      checks++; if (pend_valid !== (exp_id != 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%0d exp=%0d", c, pend_valid, exp_id != 0); end
      checks++; if (pend_id !== 4'(exp_id)) begin
        errors++; $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", c, pend_id, exp_id); end
      checks++; if (inflight !== m_infl_vec()) begin
        errors++; $display("FAIL rnd_infl cyc=%0d got=%h exp=%h", c, inflight, m_infl_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_level_detect();
    test_claim_order();
    test_rearm();
    test_edge_merge();
    test_ignored();
    test_reset_midop_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
